serial_byte_queue: RTL and testbench
====================================

Name: serial_byte_queue

Overview:
- Single-clock block that turns a strobed serial bit stream into bytes and buffers them in an 8-entry FIFO.
- Bytes are removed one at a time by a strobed dequeue request.
- Sits between a slow serial source (bit + write strobe) and a consumer that reads the FIFO's head byte and fill level.
- status_out tells the serial source whether the block can accept bits.

Parameters:
- DATA_WIDTH, 8, bits per word; also the width of data_out.
- DEPTH, 8, FIFO entries; len_out width is $clog2(DEPTH)+1 = 4.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; one clock, all state on clock.
- data_in  in  1  serial bit, sampled on a write_in rising edge.
- write_in  in  1  bit strobe; may stay high for many cycles; only its 0->1 transition counts.
- status_out  out  1  1 = ready to accept bits.
- dequeue_in  in  1  pop strobe; may stay high for many cycles; only its 0->1 transition counts.
- data_out  out  8  last byte popped from the FIFO.
- len_out  out  4  number of bytes stored, 0..8.

Behaviour:
- Edge detect:
  - Registers write_q and deq_q hold the previous input values.
  - wr_evt = write_in & ~write_q.
  - dq_evt = dequeue_in & ~deq_q.
  - Both registers clear on reset.
- Reset values:
  - status_out=0, data_out=0, len_out=0.
  - Shift register, bit count, pending flag and head/tail pointers all 0.
- Ready flag:
  - A ready register is 0 during reset and becomes 1 on the first clock edge after reset deasserts.
  - status_out = ready & ~(pending & full), so it shows a 0->1 edge after reset.
- Deserializer:
  - On a wr_evt edge with pending=0: shift <= {shift[6:0], data_in}; count++. Bits arrive MSB first.
  - The edge that captures the 8th bit sets pending=1, latches the completed byte and sets count=0.
  - A wr_evt while pending=1 is ignored: no shift, no count change.
- Push:
  - Any edge with pending=1 and the FIFO not full writes the byte at tail, advances tail (mod 8) and clears pending.
  - The push therefore happens on the edge after the 8th bit.
  - While full, the byte is held, pending stays 1 and status_out=0.
  - The hold ends on the first edge where the FIFO has room; status_out then returns to 1.
- Pop:
  - On a dq_evt edge with len>0: data_out <= mem[head], head advances (mod 8), len decrements.
  - A dq_evt with len=0 is ignored; data_out holds.
  - Between pops, data_out holds its value.
- Simultaneous events:
  - Push and pop on the same edge: len is unchanged and both pointers advance.
  - With the FIFO full and pending=1, a pop edge frees a slot. The push happens on that same edge, evaluated with full computed before the pop.
- Flags: full = (len==8); len_out is the registered count.
- Reset mid-operation:
  - A partial byte, a pending byte and all FIFO contents are discarded.
  - data_out returns to 0.

Decomposition:
- Package serial_byte_queue_pkg:
  - DATA_WIDTH, DEPTH, LEN_W localparams.
  - typedef logic [DATA_WIDTH-1:0] word_t.
- One sub-module, sync_fifo:
  - Contains mem, head/tail, count, push/pop/full/empty.
  - data_out is registered on pop.
- Edge detection and the deserializer stay in the top level of the block.

Test Plan:
- Reset held 3 cycles then released:
  - During reset: status_out=0, len_out=0, data_out=0.
  - status_out=1 one cycle after release.
- Send 0x80 as 8 bit strobes (each 10 cycles high, 10 low, MSB first):
  - len_out becomes 1 on the edge after the 8th strobe edge.
  - status_out stays 1.
- Send 0x80..0x87 (8 bytes), then 8 dequeue pulses (each 200 cycles high):
  - len_out goes 8 -> 0.
  - data_out steps 0x80, 0x81 ... 0x87, one value per pulse, not one per high cycle.
- Dequeue pulse with len_out=0: data_out holds 0x87 and len_out stays 0.
- After reset, send 9 bytes 0x88..0x90:
  - len_out=8.
  - status_out=0 after the 9th byte's 8th bit; extra write strobes are ignored.
  - One dequeue pulse: data_out=0x88, the held byte 0x90 is pushed, len_out stays 8, status_out=1.
- Reset asserted after 3 bits of a byte:
  - All outputs return to reset values.
  - The next complete byte sent is received intact; the 3 earlier bits do not appear in it.

Source files
------------

// File: rtl/serial_byte_queue_pkg.sv
// rtl/serial_byte_queue_pkg.sv - shared widths and word type for the serial byte queue
package serial_byte_queue_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int LEN_W      = $clog2(DEPTH) + 1;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DATA_WIDTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/serial_byte_queue_sync_fifo.sv
// rtl/serial_byte_queue_sync_fifo.sv - 8-entry byte FIFO with registered pop data
module sync_fifo
    import serial_byte_queue_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  word_t            push_data_i,
    input  logic             pop_i,
    output word_t            pop_data_o,
    output logic [LEN_W-1:0] len_o,
    output logic             full_o,
    output logic             push_ack_o
);

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    word_t            data_q;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full  = (len_q == LEN_W'(DEPTH));
    assign empty = (len_q == '0);

    // A pop frees the head slot on the same edge, so a full FIFO still
    // accepts a push when it is popped; the read of mem[head] sees the
    // old entry even when tail == head.
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    // Fill level: unchanged when push and pop coincide
    always_comb begin
        len_d = len_q;
        if (do_push && !do_pop) begin
            len_d = len_q + LEN_W'(1);
        end else if (do_pop && !do_push) begin
            len_d = len_q - LEN_W'(1);
        end
    end

    // Pointers, fill level and popped-data register
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            len_q  <= '0;
            data_q <= '0;
        end else begin
            len_q <= len_d;
            if (do_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PTR_W'(1);
                data_q <= mem_q[head_q];
            end
        end
    end

    // Storage array; contents are invalidated by the pointer reset alone
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign pop_data_o = data_q;
    assign len_o      = len_q;
    assign full_o     = full;
    assign push_ack_o = do_push;

endmodule

// File: rtl/serial_byte_queue.sv
// rtl/serial_byte_queue.sv - serial-to-byte deserializer feeding an 8-entry FIFO
module serial_byte_queue
    import serial_byte_queue_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    output logic             status_out,
    input  logic             dequeue_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] len_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  write_q;
    logic                  deq_q;
    logic                  ready_q;
    logic [DATA_WIDTH-2:0] shift_q;
    logic [DATA_WIDTH-2:0] shift_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  pending_q;
    logic                  pending_d;
    word_t                 byte_q;
    word_t                 byte_d;

    logic wr_evt;
    logic dq_evt;
    logic fifo_full;
    logic push_ack;
    word_t pop_data;

    // Only rising edges of the strobes count as events
    assign wr_evt = write_in & ~write_q;
    assign dq_evt = dequeue_in & ~deq_q;

    // Deserializer next state: MSB-first shift, byte latched on the 8th bit,
    // input frozen while a completed byte waits for FIFO room
    always_comb begin
        shift_d   = shift_q;
        count_d   = count_q;
        pending_d = pending_q;
        byte_d    = byte_q;
        if (push_ack) begin
            pending_d = 1'b0;
        end
        if (wr_evt && !pending_q) begin
            shift_d = {shift_q[DATA_WIDTH-3:0], data_in};
            if (count_q == LAST_BIT) begin
                byte_d    = {shift_q, data_in};
                count_d   = '0;
                pending_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Edge-detect history, ready flag and deserializer state
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q   <= 1'b0;
            deq_q     <= 1'b0;
            ready_q   <= 1'b0;
            shift_q   <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            byte_q    <= '0;
        end else begin
            write_q   <= write_in;
            deq_q     <= dequeue_in;
            ready_q   <= 1'b1;
            shift_q   <= shift_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            byte_q    <= byte_d;
        end
    end

    sync_fifo u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (pending_q),
        .push_data_i (byte_q),
        .pop_i       (dq_evt),
        .pop_data_o  (pop_data),
        .len_o       (len_out),
        .full_o      (fifo_full),
        .push_ack_o  (push_ack)
    );

    assign data_out   = pop_data;
    assign status_out = ready_q & ~(pending_q & fifo_full);

endmodule

// File: tb/tb_serial_byte_queue.sv
// tb/tb_serial_byte_queue.sv - directed self-checking bench for serial_byte_queue
module tb_serial_byte_queue;

    logic       clock;
    logic       reset;
    logic       data_in;
    logic       write_in;
    logic       status_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic [3:0] len_out;

    int errors;
    int checks;

    serial_byte_queue dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .status_out (status_out),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        data_in  = b;
        write_in = 1'b1;
        tick(10);
        write_in = 1'b0;
        tick(10);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic deq_pulse();
        dequeue_in = 1'b1;
        tick(200);
        dequeue_in = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        check("rst_status", {31'd0, status_out}, 32'd0);
        check("rst_len", {28'd0, len_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] v;
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        data_in    = 1'b0;
        write_in   = 1'b0;
        dequeue_in = 1'b0;

        // Reset held 3 cycles, status rises one cycle after release
        tick(3);
        check("rst_status", {31'd0, status_out}, 32'd0);
        check("rst_len", {28'd0, len_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("ready_after_rst", {31'd0, status_out}, 32'd1);

        // 0x80: push lands on the edge after the 8th strobe edge
        v = 8'h80;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        data_in  = v[0];
        write_in = 1'b1;
        tick(1);
        check("len_at_8th_edge", {28'd0, len_out}, 32'd0);
        tick(1);
        check("len_after_push", {28'd0, len_out}, 32'd1);
        check("status_1st_byte", {31'd0, status_out}, 32'd1);
        tick(8);
        write_in = 1'b0;
        tick(10);

        // Fill with 0x81..0x87, then drain with long dequeue pulses
        for (int b = 1; b < 8; b++) send_byte(8'h80 + 8'(b));
        check("len_full", {28'd0, len_out}, 32'd8);
        check("status_full_no_pending", {31'd0, status_out}, 32'd1);
        for (int b = 0; b < 8; b++) begin
            deq_pulse();
            check($sformatf("drain_data%0d", b), {24'd0, data_out}, 32'h80 + b);
            check($sformatf("drain_len%0d", b), {28'd0, len_out}, 32'(7 - b));
        end

        // Pop from empty: no change
        deq_pulse();
        check("empty_pop_data", {24'd0, data_out}, 32'h87);
        check("empty_pop_len", {28'd0, len_out}, 32'd0);

        // Overfill: 8 bytes stored, 9th held pending
        do_reset();
        check("data_after_reset", {24'd0, data_out}, 32'd0);
        for (int b = 0; b < 8; b++) send_byte(8'h88 + 8'(b));
        check("len_8", {28'd0, len_out}, 32'd8);
        v = 8'h90;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        data_in  = v[0];
        write_in = 1'b1;
        tick(2);
        check("status_held", {31'd0, status_out}, 32'd0);
        check("len_held", {28'd0, len_out}, 32'd8);
        tick(8);
        write_in = 1'b0;
        tick(10);
        // Extra strobes while held must be ignored
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("status_still_held", {31'd0, status_out}, 32'd0);
        dequeue_in = 1'b1;
        tick(1);
        check("held_pop_data", {24'd0, data_out}, 32'h88);
        check("held_pop_len", {28'd0, len_out}, 32'd8);
        check("held_pop_status", {31'd0, status_out}, 32'd1);
        tick(199);
        dequeue_in = 1'b0;
        tick(10);
        for (int b = 0; b < 8; b++) begin
            deq_pulse();
            check($sformatf("held_drain%0d", b), {24'd0, data_out}, 32'h89 + b);
        end
        check("held_drain_len", {28'd0, len_out}, 32'd0);
        // Bit counter must not have advanced during the ignored strobes
        send_byte(8'hA5);
        deq_pulse();
        check("after_hold_byte", {24'd0, data_out}, 32'hA5);

        // Reset after 3 bits discards the partial byte
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        check("midrst_len", {28'd0, len_out}, 32'd0);
        check("midrst_data", {24'd0, data_out}, 32'd0);
        check("midrst_status", {31'd0, status_out}, 32'd1);
        send_byte(8'h3C);
        check("midrst_len1", {28'd0, len_out}, 32'd1);
        deq_pulse();
        check("midrst_byte", {24'd0, data_out}, 32'h3C);
        check("midrst_len0", {28'd0, len_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
